// File: rtl/dcf77_pulse_decoder.sv
// ---------------------------------------------------------------------------------------------
// dcf77_pulse_decoder
//
// Decodes the amplitude-keyed second pulses of a DCF77 receiver into a 59-bit minute frame.
// The receiver output is synchronised, optionally glitch-filtered, and timed in milliseconds
// between edges. A three-state FSM (SYNC / HIGH / LOW) classifies pulse and gap lengths.
//
// Optional feature macro: DCF77_GLITCH_FILTER_EN
//   When defined, the synchronised input must stay at its new value for FILTER_CYCLES
//   consecutive clk cycles before the internal level follows it.
//
// Parameters
//   CLOCK_FREQUENCY : clk frequency in Hz (CLOCK_FREQUENCY/1000 must be an integer >= 2)
//   FILTER_CYCLES   : glitch-filter stability window in clk cycles
//
// Ports
//   clk                : system clock (single clock domain)
//   reset              : synchronous active-high reset
//   dcf77_non_inverted : asynchronous receiver output, high = carrier-reduced pulse
//   dcf_sec            : one-cycle strobe per accepted second bit
//   dcf_minute         : one-cycle strobe when a full 59-bit frame is closed by a minute marker
//   dcf_outputbits     : received bits, bit n = DCF77 second n
//   decode_error       : one-cycle strobe on any framing or timing violation
//   synced             : high while the decoder is not hunting for a minute marker
// ---------------------------------------------------------------------------------------------
module dcf77_pulse_decoder #(
    parameter int unsigned CLOCK_FREQUENCY = 16000000,
    parameter int unsigned FILTER_CYCLES   = CLOCK_FREQUENCY / 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcf77_non_inverted,
    output logic        dcf_sec,
    output logic        dcf_minute,
    output logic [58:0] dcf_outputbits,
    output logic        decode_error,
    output logic        synced
);

    localparam int unsigned TICK_DIV = CLOCK_FREQUENCY / 1000;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Pulse / gap classification limits in ms
    localparam logic [11:0] MS_BIT0_MIN  = 12'd60;
    localparam logic [11:0] MS_BIT0_MAX  = 12'd140;
    localparam logic [11:0] MS_BIT1_MIN  = 12'd160;
    localparam logic [11:0] MS_BIT1_MAX  = 12'd240;
    localparam logic [11:0] MS_HIGH_TO   = 12'd1000;
    localparam logic [11:0] MS_GAP_MIN   = 12'd700;
    localparam logic [11:0] MS_GAP_MAX   = 12'd1000;
    localparam logic [11:0] MS_MARKER    = 12'd1500;
    localparam logic [11:0] MS_LOST      = 12'd2500;
    localparam logic [11:0] MS_SAT       = 12'd4095;
    localparam logic [5:0]  FRAME_BITS   = 6'd59;

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // FILTER_CYCLES only shapes the design when the glitch filter is built in
    if (FILTER_CYCLES == 0) begin : g_filter_window_unused
    end

    // -----------------------------------------------------------------------------------------
    // Input synchroniser
    // -----------------------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= dcf77_non_inverted;
            r_sync2 <= r_sync1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Level source: optional glitch filter
    // -----------------------------------------------------------------------------------------
    logic w_level;

`ifdef DCF77_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);

    logic [FILT_W-1:0] r_filt_cnt;
    logic              r_level;

    // Counts consecutive cycles the synchronised input disagrees with the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_cnt <= '0;
            r_level    <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_W'(FILTER_CYCLES - 1)) begin
            r_level    <= r_sync2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    // -----------------------------------------------------------------------------------------
    // Edge detection
    // -----------------------------------------------------------------------------------------
    logic r_level_prev;
    logic w_rise;
    logic w_fall;
    logic w_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_prev <= 1'b0;
        end else begin
            r_level_prev <= w_level;
        end
    end

    assign w_rise = w_level & ~r_level_prev;
    assign w_fall = ~w_level & r_level_prev;
    assign w_edge = w_rise | w_fall;

    // -----------------------------------------------------------------------------------------
    // 1 ms prescaler and ms-since-last-edge counter (both restart on every edge)
    // -----------------------------------------------------------------------------------------
    logic [PRE_W-1:0] r_prescaler;
    logic             w_tick;
    logic [11:0]      r_ms_cnt;

    assign w_tick = (r_prescaler == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler <= '0;
        end else if (w_edge || w_tick) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_cnt <= '0;
        end else if (w_edge) begin
            r_ms_cnt <= '0;
        end else if (w_tick && (r_ms_cnt != MS_SAT)) begin
            r_ms_cnt <= r_ms_cnt + 12'd1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Frame FSM (edge tests see the count accumulated before the edge clears it)
    // -----------------------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [5:0]  r_bit_idx;
    logic [5:0]  w_idx_nxt;
    logic [58:0] r_bits;
    logic        w_sec;
    logic        w_minute;
    logic        w_error;
    logic        w_is_bit0;
    logic        w_is_bit1;
    logic        w_gap_ok;

    assign w_is_bit0 = (r_ms_cnt >= MS_BIT0_MIN) && (r_ms_cnt <= MS_BIT0_MAX);
    assign w_is_bit1 = (r_ms_cnt >= MS_BIT1_MIN) && (r_ms_cnt <= MS_BIT1_MAX);
    assign w_gap_ok  = (r_ms_cnt >= MS_GAP_MIN) && (r_ms_cnt <= MS_GAP_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_bit_idx;
        w_sec       = 1'b0;
        w_minute    = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_rise && (r_ms_cnt >= MS_MARKER)) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    // The index guard keeps a write from ever landing beyond bit 58
                    if ((w_is_bit0 || w_is_bit1) && (r_bit_idx < FRAME_BITS)) begin
                        w_sec       = 1'b1;
                        w_idx_nxt   = r_bit_idx + 6'd1;
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_error     = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end
                end else if (r_ms_cnt >= MS_HIGH_TO) begin
                    w_error     = 1'b1;
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    if (r_ms_cnt >= MS_MARKER) begin
                        // A marker always restarts the frame; it only counts if complete
                        if (r_bit_idx == FRAME_BITS) begin
                            w_minute = 1'b1;
                        end else begin
                            w_error = 1'b1;
                        end
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_HIGH;
                    end else if (w_gap_ok && (r_bit_idx < FRAME_BITS)) begin
                        w_state_nxt = ST_HIGH;
                    end else begin
                        w_error     = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end
                end else if (r_ms_cnt >= MS_LOST) begin
                    w_error     = 1'b1;
                    w_state_nxt = ST_SYNC;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SYNC;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_idx_nxt;
        end
    end

    // Bit store only changes on accepted bits, so it survives errors and SYNC
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bits <= '0;
        end else if (w_sec) begin
            r_bits[r_bit_idx] <= w_is_bit1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs: strobes are decoded from registered state and forced low during reset
    // -----------------------------------------------------------------------------------------
    assign dcf_sec        = w_sec & ~reset;
    assign dcf_minute     = w_minute & ~reset;
    assign decode_error   = w_error & ~reset;
    assign synced         = (r_state != ST_SYNC) & ~reset;
    assign dcf_outputbits = r_bits & {59{~reset}};

endmodule

// File: tb/tb_dcf77_pulse_decoder.sv
// ---------------------------------------------------------------------------------------------
// tb_dcf77_pulse_decoder
//
// Scoreboard bench. The stimulus process drives randomized pulse/gap lengths (in ms) and a
// millisecond-level reference model predicts each strobe, pushing it into a queue together with
// the expected bit vector and an arrival window. A monitor pops and compares whenever the DUT
// raises any strobe.
// ---------------------------------------------------------------------------------------------
module tb_dcf77_pulse_decoder;

    localparam int unsigned CLK_HZ = 2000;
    localparam int          P      = CLK_HZ / 1000;  // clk cycles per ms

    typedef enum int {EvSec, EvMinute, EvError} ev_kind_e;

    typedef struct {
        ev_kind_e    kind;
        logic [58:0] vec;
        logic        synced_after;
        int          lo;
        int          hi;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        din;
    logic        dcf_sec;
    logic        dcf_minute;
    logic [58:0] dcf_outputbits;
    logic        decode_error;
    logic        synced;

    dcf77_pulse_decoder #(
        .CLOCK_FREQUENCY(CLK_HZ)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .dcf77_non_inverted(din),
        .dcf_sec           (dcf_sec),
        .dcf_minute        (dcf_minute),
        .dcf_outputbits    (dcf_outputbits),
        .decode_error      (decode_error),
        .synced            (synced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // -----------------------------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------------------------
    logic        pend_vec_v  = 1'b0;
    logic [58:0] pend_vec;
    logic        pend_sync_v = 1'b0;
    logic        pend_sync;

    always @(negedge clk) begin
        int  nstb;
        ev_t ev;
        if (reset) begin
            pend_vec_v  = 1'b0;
            pend_sync_v = 1'b0;
        end else begin
            if (pend_vec_v) begin
                check("bits_after_sec", {5'b0, dcf_outputbits}, {5'b0, pend_vec});
                pend_vec_v = 1'b0;
            end
            if (pend_sync_v) begin
                check("synced_after_error", {63'b0, synced}, {63'b0, pend_sync});
                pend_sync_v = 1'b0;
            end
            nstb = int'(dcf_sec) + int'(dcf_minute) + int'(decode_error);
            if (nstb > 1) check("strobe_exclusive", 64'(nstb), 64'd1);
            if (nstb != 0) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", {61'b0, dcf_sec, dcf_minute, decode_error}, 64'd0);
                end else begin
                    ev = q.pop_front();
                    check("strobe_kind", {61'b0, dcf_sec, dcf_minute, decode_error},
                          (ev.kind == EvSec) ? 64'd4 : (ev.kind == EvMinute) ? 64'd2 : 64'd1);
                    n_checks++;
                    if (cyc >= ev.lo && cyc <= ev.hi) n_pass++;
                    else $display("FAIL strobe_time: cycle %0d, expected %0d..%0d",
                                  cyc, ev.lo, ev.hi);
                    case (ev.kind)
                        EvSec: begin
                            pend_vec   = ev.vec;
                            pend_vec_v = 1'b1;
                        end
                        EvMinute: begin
                            check("frame_at_minute", {5'b0, dcf_outputbits}, {5'b0, ev.vec});
                        end
                        default: begin
                            pend_sync   = ev.synced_after;
                            pend_sync_v = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Reference model (ms-level rules) and stimulus
    // -----------------------------------------------------------------------------------------
    logic        m_in_frame = 1'b0;
    int          m_idx      = 0;
    logic [58:0] m_bits     = '0;
    int          m_low_ms   = 0;
    int          t_fall     = 0;

    task automatic push_ev(input ev_kind_e k, input logic s, input int lo, input int hi);
        ev_t e;
        e.kind         = k;
        e.vec          = m_bits;
        e.synced_after = s;
        e.lo           = lo;
        e.hi           = hi;
        q.push_back(e);
    endtask

    task automatic wait_ms(input int ms);
        repeat (ms * P) @(negedge clk);
    endtask

    // Evaluate a rising edge preceded by m_low_ms of low
    task automatic model_rise();
        if (!m_in_frame) begin
            if (m_low_ms >= 1500) begin
                m_in_frame = 1'b1;
                m_idx      = 0;
            end
        end else if (m_low_ms >= 1500) begin
            if (m_idx == 59) push_ev(EvMinute, 1'b1, cyc, cyc + 8);
            else             push_ev(EvError, 1'b1, cyc, cyc + 8);
            m_idx = 0;
        end else if (!(m_low_ms >= 700 && m_low_ms <= 1000 && m_idx <= 58)) begin
            push_ev(EvError, 1'b0, cyc, cyc + 8);
            m_in_frame = 1'b0;
        end
    endtask

    // Evaluate a falling edge after h ms of high
    task automatic model_fall(input int h);
        if (m_in_frame) begin
            if ((h >= 60 && h <= 140) || (h >= 160 && h <= 240)) begin
                m_bits[m_idx] = (h >= 160);
                push_ev(EvSec, 1'b1, cyc, cyc + 8);
                m_idx++;
            end else begin
                push_ev(EvError, 1'b0, cyc, cyc + 8);
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic idle(input int l);
        if (m_in_frame && m_low_ms < 2500 && m_low_ms + l >= 2500) begin
            push_ev(EvError, 1'b0, t_fall + 2500 * P - 4, t_fall + 2500 * P + 12);
            m_in_frame = 1'b0;
        end
        m_low_ms += l;
`ifdef DCF77_GLITCH_FILTER_EN
        wait_ms(l / 2);
        din = 1'b1;
        @(negedge clk);
        din = 1'b0;
        repeat (l * P - (l / 2) * P - 1) @(negedge clk);
`else
        wait_ms(l);
`endif
    endtask

    task automatic pulse(input int h, input int l);
        model_rise();
        din = 1'b1;
        wait_ms(h);
        model_fall(h);
        t_fall   = cyc;
        din      = 1'b0;
        m_low_ms = 0;
        idle(l);
    endtask

    task automatic rand_bit(input int l);
        int h;
        h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(165, 200))
                                        : int'($urandom_range(65, 100));
        pulse(h, l);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sec"},    {63'b0, dcf_sec},      64'd0);
        check({tag, "_minute"}, {63'b0, dcf_minute},   64'd0);
        check({tag, "_error"},  {63'b0, decode_error}, 64'd0);
        check({tag, "_synced"}, {63'b0, synced},       64'd0);
        check({tag, "_bits"},   {5'b0, dcf_outputbits}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("synced_after_reset", {63'b0, synced}, 64'd0);

        // Acquire sync, a few bits, then an early marker that resynchronises the frame
        idle(1600);
        for (int i = 0; i < 4; i++) rand_bit((i == 3) ? 1600 : int'($urandom_range(705, 730)));

        // Complete frame closed by a minute marker
        for (int i = 0; i < 59; i++) rand_bit((i == 58) ? 1600 : int'($urandom_range(705, 730)));

        // Next frame, aborted by reset mid-frame
        for (int i = 0; i < 3; i++) rand_bit((i == 2) ? 300 : int'($urandom_range(705, 730)));
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midframe_reset");
        reset      = 1'b0;
        m_in_frame = 1'b0;
        m_idx      = 0;
        m_bits     = '0;
        m_low_ms   = 0;

        // Re-acquire, then lose the signal for 2600 ms
        idle(1600);
        rand_bit(int'($urandom_range(705, 730)));
        rand_bit(2600);
        check("bits_kept_after_loss", {5'b0, dcf_outputbits}, {5'b0, m_bits});
        check("synced_after_loss", {63'b0, synced}, 64'd0);

        // Marker then an out-of-range 150 ms pulse
        pulse(150, 200);
        check("synced_after_bad_pulse", {63'b0, synced}, 64'd0);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            n_checks++;
            $display("FAIL missing_strobe: kind %0d never seen, expected by cycle %0d",
                     int'(e.kind), e.hi);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
